cnt_burst_arb: RTL
==================

// Module: cnt_burst_arb
// PURPOSE
//  Round-robin arbiter/sequencer sharing one base/addr/cnt address counter among
//  N requesters. Grants one requester, loads the counter with that requester's
//  base (en/inp), runs a burst of (len+1) beats and observes cnt to end it.
//  Sits between the requester ports and the counter instance; the counter shares clk/rst.
// PARAMETERS
//  W   16  address/counter width (matches counter width)
//  N   4   number of requesters (2..8)
//  LW  8   burst length field width; field value = beats-1
// PORTS
//  clk       in   1      clock; all state updates on posedge
//  rst       in   1      synchronous, active-high reset
//  req       in   N      per-requester request, level
//  req_base  in   N*W    requester i base address at [i*W +: W]
//  req_len   in   N*LW   requester i beats-1 at [i*LW +: LW]
//  abort     in   1      terminate current grant
//  cnt_fb    in   W      counter cnt output (feedback)
//  ctr_en    out  1      drives counter en
//  ctr_inp   out  W      drives counter inp
//  gnt       out  N      one-hot grant, held for the whole transaction
//  gnt_id    out  3      index of granted requester
//  beat_vld  out  1      counter addr is a valid burst beat this cycle
//  done      out  1      one-cycle pulse on last beat
//  busy      out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, gnt_id=0, ctr_en=0, ctr_inp=0, beat_vld=0, done=0,
//   busy=0, rr_ptr=N-1 (requester 0 has top priority after reset). rst wins over everything.
//  FSM (Moore except done):
//   IDLE: if |req: winner = first set req at index rr_ptr+1, +2, ... (mod N);
//     capture base_q=req_base[w], len_q=req_len[w], gnt_id=w, rr_ptr=w; -> LOAD.
//     Else stay. No output asserted.
//   LOAD (1 cycle): ctr_en=1, ctr_inp=base_q, gnt=onehot(gnt_id); -> RUN.
//   RUN: ctr_en=0, ctr_inp=0, beat_vld=1, gnt held. Counter shows addr=base_q+k,
//     cnt=k on beat k. done=(cnt_fb==len_q, zero-extended to W). On done -> IDLE.
//  Latency: req seen in IDLE at cycle t -> LOAD t+1 -> first beat t+2 ->
//   last beat t+2+len_q -> IDLE t+3+len_q. One idle bubble between grants.
//  len_q=0: single beat; done on first RUN cycle.
//  Wrap-around: addr wraps mod 2^W inside the counter; arbiter ignores addr.
//  abort in LOAD or RUN: -> IDLE next cycle; that cycle's outputs still per state,
//   but done forced 0. rr_ptr stays advanced (aborted requester loses priority).
//  abort in IDLE: ignored.
//  req deasserted during LOAD/RUN: ignored; burst completes. req/req_base/req_len
//   are sampled only in IDLE.
//  rst during LOAD/RUN: transaction dropped, all outputs to reset values next cycle.
//  Invariants: gnt is 0 or one-hot; gnt!=0 iff state in {LOAD,RUN};
//   ctr_en only in LOAD; done implies beat_vld.
// TESTING
//  1. rst, then req=4'b0001, base0=16'h7604, len0=3 -> ctr_en pulse with inp 16'h7604;
//     beats addr 7604..7607, cnt 0..3; done with cnt_fb=3; gnt=0001 for 5 cycles.
//  2. req=4'b1111 held, all len=0 -> grant order 0,1,2,3,0; one beat each, 3-cycle period.
//  3. base=16'hFFFE, len=3 -> addr FFFE,FFFF,0000,0001; done on 4th beat.
//  4. len=5, abort on 2nd RUN cycle -> IDLE next cycle, done never 1; next req=0011
//     grants 1 if aborted grant was 0.
//  5. rst asserted in RUN (len=10, beat 4) -> next cycle gnt=0, beat_vld=0,
//     rr_ptr=3; then req=1000 with req=0001 concurrently -> requester 0 wins.
//  6. req drops to 0 in LOAD -> burst still runs len+1 beats and pulses done.

Source files
------------

// File: rtl/cnt_burst_arb.sv
// Round-robin arbiter that shares one external base/addr/cnt counter among N requesters.
// Each grant loads the counter with the winner's base and runs a (len+1)-beat burst.
module cnt_burst_arb #(
    parameter int W  = 16,
    parameter int N  = 4,
    parameter int LW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  req_base,
    input  logic [N*LW-1:0] req_len,
    input  logic            abort,
    input  logic [W-1:0]    cnt_fb,
    output logic            ctr_en,
    output logic [W-1:0]    ctr_inp,
    output logic [N-1:0]    gnt,
    output logic [2:0]      gnt_id,
    output logic            beat_vld,
    output logic            done,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t        state_r;
    logic [LW-1:0] len_r;
    logic [2:0]    ptr_r;
    logic [2:0]    win_s;
    logic          win_vld_s;
    logic          last_s;

    // Round-robin search: first asserted request after the last winner.
    always_comb begin
        win_s     = 3'd0;
        win_vld_s = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!win_vld_s && req[(int'(ptr_r) + k) % N]) begin
                win_vld_s = 1'b1;
                win_s     = 3'((int'(ptr_r) + k) % N);
            end else begin
                win_vld_s = win_vld_s;
            end
        end
    end

    // The counter restarts at cnt=0 on the first beat, so cnt==len marks the last beat.
    assign last_s = (cnt_fb == W'(len_r));
    assign done   = beat_vld & last_s & ~abort;

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            len_r    <= {LW{1'b0}};
            ptr_r    <= 3'(N - 1);
            gnt_id   <= 3'd0;
            gnt      <= {N{1'b0}};
            ctr_en   <= 1'b0;
            ctr_inp  <= {W{1'b0}};
            beat_vld <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (win_vld_s) begin
                        state_r <= LOAD;
                        len_r   <= req_len[int'(win_s)*LW +: LW];
                        ptr_r   <= win_s;
                        gnt_id  <= win_s;
                        gnt     <= {{(N-1){1'b0}}, 1'b1} << win_s;
                        ctr_en  <= 1'b1;
                        ctr_inp <= req_base[int'(win_s)*W +: W];
                        busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    ctr_en  <= 1'b0;
                    ctr_inp <= {W{1'b0}};
                    if (abort) begin
                        state_r <= IDLE;
                        gnt     <= {N{1'b0}};
                        busy    <= 1'b0;
                    end else begin
                        state_r  <= RUN;
                        beat_vld <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort || last_s) begin
                        state_r  <= IDLE;
                        gnt      <= {N{1'b0}};
                        beat_vld <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    gnt      <= {N{1'b0}};
                    ctr_en   <= 1'b0;
                    ctr_inp  <= {W{1'b0}};
                    beat_vld <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
